// File: rtl/mem_io_pkg.sv
// ============================================================================
// mem_io_pkg : shared decode constants and read-source encoding
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mem_io_pkg;

   localparam logic [1:0]  IO_REGION    = 2'b11;
   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

   typedef enum logic [1:0] {
      SRC_RAM  = 2'd0,
      SRC_RX   = 2'd1,
      SRC_CLK  = 2'd2,
      SRC_ZERO = 2'd3
   } rd_src_e;

endpackage

`default_nettype wire

// File: rtl/ram_byte_sync.sv
// ============================================================================
// ram_byte_sync : single-port synchronous byte RAM, write-first, file init
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ram_byte_sync #(
    parameter int ADDR_WIDTH = 17,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    logic [7:0] r_mem [2**ADDR_WIDTH];

    // Write-first: a write cycle returns the byte just written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata       <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// mem_io_responder : RAM / I/O responder for the CPU byte bus with UART TX
//                    FIFO, RX byte port, cycle counter and stop flag
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH       = 16,
   parameter int FULL_MARGIN    = 2,
   parameter     RAM_INIT       = ""
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_finished,
   output logic        tx_overflow
);

   localparam int               PTR_W   = $clog2(TX_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);

   logic [17:0]      w_addr;
   logic             w_is_io, w_uart, w_clk_rd, w_clk_wr, w_ram_we;
   logic             w_unused_addr;
   logic [7:0]       w_ram_q, w_snap_byte;
   logic             w_pop, w_push_req, w_push, w_fifo_full;
   logic [7:0]       w_push_data;

   rd_src_e          r_src;
   logic [7:0]       r_rx_byte, r_clk_byte;
   logic [31:0]      r_cnt, r_snap;
   logic [7:0]       r_fifo [TX_DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full, r_ovf, r_fin;

   assign w_addr        = mem_a[17:0];
   assign w_unused_addr = ^mem_a[31:18];
   assign w_is_io       = (w_addr[17:16] == IO_REGION);
   assign w_uart        = (w_addr == IO_UART_ADDR);
   assign w_clk_rd      = (w_addr[17:2] == IO_CLK_ADDR[17:2]);
   assign w_clk_wr      = (w_addr == IO_CLK_ADDR);
   assign w_ram_we      = mem_wr & ~w_is_io;
   assign w_snap_byte   = r_snap[{w_addr[1:0], 3'b000} +: 8];

   ram_byte_sync #(
      .ADDR_WIDTH (RAM_ADDR_WIDTH),
      .INIT_FILE  (RAM_INIT)
   ) u_ram (
      .clk     (clk_in),
      .i_we    (w_ram_we),
      .i_addr  (mem_a[RAM_ADDR_WIDTH-1:0]),
      .i_wdata (mem_dout),
      .o_rdata (w_ram_q)
   );

   // RX pop is combinational so the UART sees it in the request cycle.
   assign rx_pop = ~rst_in & ~mem_wr & w_uart & rx_valid;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_src      <= SRC_ZERO;
         r_rx_byte  <= 8'h00;
         r_clk_byte <= 8'h00;
         r_snap     <= 32'd0;
         r_cnt      <= 32'd0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
         r_src <= SRC_ZERO;
         if (!mem_wr) begin
            if (!w_is_io) begin
               r_src <= SRC_RAM;
            end else if (w_uart) begin
               r_src     <= SRC_RX;
               r_rx_byte <= rx_valid ? rx_data : 8'h00;
            end else if (w_clk_rd) begin
               r_src <= SRC_CLK;
               if (w_addr[1:0] == 2'd0) begin
                  r_snap     <= r_cnt;
                  r_clk_byte <= r_cnt[7:0];
               end else begin
                  r_clk_byte <= w_snap_byte;
               end
            end
         end
      end
   end

   always_comb begin
      mem_din = 8'h00;
      case (r_src)
         SRC_RAM:  mem_din = w_ram_q;
         SRC_RX:   mem_din = r_rx_byte;
         SRC_CLK:  mem_din = r_clk_byte;
         default:  mem_din = 8'h00;
      endcase
   end

   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign tx_valid    = (r_count != '0);
   assign w_fifo_full = (r_count == DEPTH_C);
   assign w_pop       = tx_valid & tx_ready;
   assign w_push_req  = mem_wr & ((w_uart & (mem_dout != 8'h00)) | w_clk_wr);
   assign w_push      = w_push_req & (~w_fifo_full | w_pop);
   assign w_push_data = w_clk_wr ? 8'h00 : mem_dout;
   assign tx_data     = r_fifo[r_rptr];

   always_ff @(posedge clk_in) begin
      if (w_push) r_fifo[r_wptr] <= w_push_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         r_full  <= ((DEPTH_C - r_count) <= CNT_W'(FULL_MARGIN));
         if (w_push_req && w_fifo_full && !w_pop) r_ovf <= 1'b1;
         if (mem_wr && w_clk_wr)                  r_fin <= 1'b1;
      end
   end

   assign io_buffer_full   = r_full;
   assign tx_overflow      = r_ovf;
   assign program_finished = r_fin;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// tb_mem_io_responder : scoreboard bench with a queue/array reference model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

   localparam int DEPTH  = 16;
   localparam int MARGIN = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_finished;
   logic        tx_overflow;

   mem_io_responder #(
      .RAM_ADDR_WIDTH (17),
      .TX_DEPTH       (DEPTH),
      .FULL_MARGIN    (MARGIN),
      .RAM_INIT       ("")
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .mem_a            (mem_a),
      .mem_dout         (mem_dout),
      .mem_wr           (mem_wr),
      .mem_din          (mem_din),
      .io_buffer_full   (io_buffer_full),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_pop           (rx_pop),
      .program_finished (program_finished),
      .tx_overflow      (tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   int edge_n = 0;
   always @(posedge clk_in) edge_n <= edge_n + 1;

   typedef struct {
      int         e;
      bit         rd_chk;
      logic [7:0] din;
      bit         full;
      bit         valid;
      logic [7:0] head;
      bit         ovf;
      bit         fin;
   } post_t;

   typedef struct {
      int e;
      bit pop;
   } pre_t;

   post_t postq[$];
   pre_t  preq[$];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  m_tx[$];
   logic [31:0] m_cnt  = 0;
   logic [31:0] m_snap = 0;
   bit          m_ovf  = 0;
   bit          m_fin  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
   endtask

   // Monitor: post-edge state for edge_n, pre-edge rx_pop for the coming edge.
   post_t mq;
   pre_t  mp;
   always @(negedge clk_in) begin
      if (postq.size() > 0 && postq[0].e == edge_n) begin
         mq = postq.pop_front();
         if (mq.rd_chk) chk("mem_din", {24'd0, mem_din}, {24'd0, mq.din});
         chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, mq.full});
         chk("tx_valid", {31'd0, tx_valid}, {31'd0, mq.valid});
         if (mq.valid) chk("tx_data", {24'd0, tx_data}, {24'd0, mq.head});
         chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, mq.ovf});
         chk("program_finished", {31'd0, program_finished}, {31'd0, mq.fin});
      end
      if (preq.size() > 0 && preq[0].e == edge_n + 1) begin
         mp = preq.pop_front();
         chk("rx_pop", {31'd0, rx_pop}, {31'd0, mp.pop});
      end
   end

   // One bus cycle: drive inputs, predict results, advance one edge.
   task automatic cyc(input logic [31:0] a, input logic [7:0] d, input bit wr,
                      input bit rdy, input bit rxv, input logic [7:0] rxd);
      pre_t        p;
      post_t       q;
      int          c;
      bit          pop;
      bit          io;
      logic [17:0] a18;
      logic [31:0] sh;
      rst_in   = 1'b0;
      mem_a    = a;
      mem_dout = d;
      mem_wr   = wr;
      tx_ready = rdy;
      rx_valid = rxv;
      rx_data  = rxd;
      a18      = a[17:0];
      io       = (a18[17:16] == 2'b11);
      c        = m_tx.size();
      pop      = (c > 0) && rdy;
      q.rd_chk = 0;
      q.din    = 8'h00;
      p.pop    = 0;
      if (!wr) begin
         if (!io) begin
            if (m_ram.exists(int'(a[16:0]))) begin
               q.rd_chk = 1;
               q.din    = m_ram[int'(a[16:0])];
            end
         end else if (a18 == 18'h30000) begin
            q.rd_chk = 1;
            q.din    = rxv ? rxd : 8'h00;
            p.pop    = rxv;
         end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
            if (a18 == 18'h30004) m_snap = m_cnt;
            sh       = m_snap >> (8 * int'(a18 - 18'h30004));
            q.rd_chk = 1;
            q.din    = sh[7:0];
         end else begin
            q.rd_chk = 1;
            q.din    = 8'h00;
         end
      end
      if (pop) void'(m_tx.pop_front());
      if (wr && ((a18 == 18'h30000 && d != 8'h00) || a18 == 18'h30004)) begin
         if (c < DEPTH || pop) m_tx.push_back((a18 == 18'h30004) ? 8'h00 : d);
         else m_ovf = 1;
      end
      if (wr && a18 == 18'h30004) m_fin = 1;
      if (wr && !io) m_ram[int'(a[16:0])] = d;
      q.full  = (DEPTH - c) <= MARGIN;
      q.valid = (m_tx.size() > 0);
      q.head  = q.valid ? m_tx[0] : 8'h00;
      q.ovf   = m_ovf;
      q.fin   = m_fin;
      q.e     = edge_n + 1;
      p.e     = edge_n + 1;
      postq.push_back(q);
      preq.push_back(p);
      @(posedge clk_in);
      #1;
      m_cnt = m_cnt + 32'd1;
   endtask

   task automatic do_reset(input logic [31:0] a, input int n);
      pre_t  p;
      post_t q;
      for (int i = 0; i < n; i++) begin
         rst_in   = 1'b1;
         mem_a    = a;
         mem_wr   = 1'b0;
         mem_dout = 8'h00;
         tx_ready = 1'b0;
         rx_valid = 1'b1;
         rx_data  = 8'h5A;
         p.e = edge_n + 1; p.pop = 0;
         q.e = edge_n + 1; q.rd_chk = 1; q.din = 8'h00; q.full = 0;
         q.valid = 0; q.head = 8'h00; q.ovf = 0; q.fin = 0;
         postq.push_back(q);
         preq.push_back(p);
         @(posedge clk_in);
         #1;
      end
      m_tx.delete();
      m_ovf  = 0;
      m_fin  = 0;
      m_cnt  = 0;
      m_snap = 0;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(32'h0003_0010, 8'h00, 1'b0, rdy, 1'b0, 8'h00);
   endtask

   logic [31:0] r_hi;
   logic [17:0] r_a;
   logic [7:0]  r_d;
   int          kind;

   initial begin
      rst_in   = 1'b1;
      mem_a    = 32'd0;
      mem_dout = 8'h00;
      mem_wr   = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(posedge clk_in);
      #1;

      do_reset(32'h0003_0000, 2);

      // RAM write then read back
      cyc(32'h0000_0100, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(32'h0000_0100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);

      // nonzero byte queued, zero byte ignored
      cyc(32'h0003_0000, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(32'h0003_0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(2, 1'b0);
      idle(2, 1'b1);

      // fill to depth, then one more write overflows
      for (int i = 0; i < 17; i++) cyc(32'h0003_0000, 8'(i + 1), 1'b1, 1'b0, 1'b0, 8'h00);
      idle(2, 1'b0);
      // full with simultaneous pop still accepts the push
      cyc(32'h0003_0000, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00);
      idle(20, 1'b1);

      // RX read with and without a byte available
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h37);
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h37);
      idle(1, 1'b0);

      // counter snapshot after ~100 cycles
      do_reset(32'h0000_0100, 1);
      idle(100, 1'b0);
      for (int i = 0; i < 4; i++) cyc(32'h0003_0004 + 32'(i), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);

      // stop write, then reset while the byte is still queued
      cyc(32'h0003_0004, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(3, 1'b0);
      cyc(32'h0003_0000, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00);
      do_reset(32'h0000_0100, 1);
      idle(2, 1'b1);

      // randomized mix
      for (int i = 0; i < 600; i++) begin
         r_hi = $urandom();
         kind = $urandom_range(0, 9);
         r_d  = 8'($urandom());
         case (kind)
            0, 1, 2, 3: begin
               r_a = {1'($urandom_range(0, 1)), 1'b0, 16'(16'h0200 + 16'($urandom_range(0, 15)))};
               cyc({r_hi[31:18], r_a}, r_d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3), 1'b0, 8'h00);
            end
            4, 5: begin
               if ($urandom_range(0, 3) == 0) r_d = 8'h00;
               cyc({r_hi[31:18], 18'h30000}, r_d, 1'b1, 1'($urandom_range(0, 9) < 3), 1'b0, 8'h00);
            end
            6: cyc({r_hi[31:18], 18'h30000}, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_d);
            7: cyc({r_hi[31:18], 18'h30004 + 18'($urandom_range(0, 3))}, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            8: cyc({r_hi[31:18], 18'h30008 + 18'($urandom_range(0, 7))}, r_d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, r_d);
            default: begin
               if ($urandom_range(0, 19) == 0) cyc({r_hi[31:18], 18'h30004}, r_d, 1'b1, 1'b0, 1'b0, 8'h00);
               else idle(1, 1'($urandom_range(0, 1)));
            end
         endcase
      end
      idle(2, 1'b0);

      n_chk++;
      if (postq.size() <= 1 && preq.size() <= 1) n_pass++;
      else $display("FAIL scoreboard_drain: post=%0d pre=%0d left, expected at most 1", postq.size(), preq.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
